// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches always win, host accesses are
// captured on a hostSelect rising edge and issued in the first display-idle cycle.
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int WAIT_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              dispReq,
  input  logic [ADDR_W-1:0] dispAddr,
  output logic              dispRdValid,
  output logic [DATA_W-1:0] dispRdData,
  input  logic              hostSelect,
  input  logic              hostRd,
  input  logic [ADDR_W-1:0] hostAddr,
  input  logic [DATA_W-1:0] hostWrData,
  output logic [DATA_W-1:0] hostRdData,
  output logic              hostDone,
  output logic              hostOverrun,
  output logic [WAIT_W-1:0] hostWaitMax,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWrData,
  output logic              memWe,
  input  logic [DATA_W-1:0] memRdData
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_RET  = 2'd2;

  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  logic [1:0]        r_state;
  logic              r_hs_d;
  logic              r_p_rd;
  logic [ADDR_W-1:0] r_p_addr;
  logic [DATA_W-1:0] r_p_data;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] r_wait_max;
  logic [DATA_W-1:0] r_host_rd_data;
  logic              r_host_done;
  logic              r_overrun;
  logic              r_disp_valid;

  logic w_host_edge;
  logic w_host_grant;

  assign w_host_edge  = hostSelect & ~r_hs_d;
  // Gated by nrst so a pending write can never reach the VRAM during reset.
  assign w_host_grant = nrst & (r_state == S_PEND) & ~dispReq;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    memAddr = dispAddr;
    memWe   = 1'b0;
    if (w_host_grant) begin
      memAddr = r_p_addr;
      memWe   = ~r_p_rd;
    end
  end

  assign memWrData   = r_p_data;
  assign dispRdData  = memRdData;
  assign dispRdValid = r_disp_valid;
  assign hostRdData  = r_host_rd_data;
  assign hostDone    = r_host_done;
  assign hostOverrun = r_overrun;
  assign hostWaitMax = r_wait_max;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state        <= S_IDLE;
      r_hs_d         <= 1'b0;
      r_p_rd         <= 1'b0;
      r_p_addr       <= '0;
      r_p_data       <= '0;
      r_wait_cnt     <= '0;
      r_wait_max     <= '0;
      r_host_rd_data <= '0;
      r_host_done    <= 1'b0;
      r_overrun      <= 1'b0;
      r_disp_valid   <= 1'b0;
    end else begin
      r_hs_d       <= hostSelect;
      r_disp_valid <= dispReq;
      r_host_done  <= 1'b0;

      if (w_host_edge && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_host_edge) begin
            r_p_rd     <= hostRd;
            r_p_addr   <= hostAddr;
            r_p_data   <= hostWrData;
            r_wait_cnt <= '0;
            r_state    <= S_PEND;
          end
        end
        S_PEND: begin
          if (w_host_grant) begin
            if (r_wait_cnt > r_wait_max) begin
              r_wait_max <= r_wait_cnt;
            end
            if (r_p_rd) begin
              r_state <= S_RET;
            end else begin
              r_host_done <= 1'b1;
              r_state     <= S_IDLE;
            end
          end else if (r_wait_cnt != '1) begin
            r_wait_cnt <= r_wait_cnt + WAIT_ONE;
          end
        end
        S_RET: begin
          r_host_rd_data <= memRdData;
          r_host_done    <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: behavioural VRAM, vector table for the
// basic write/read path, scoreboarded display and host returns, corner-case sequences.
module tb_vram_arbiter;

  logic        clk;
  logic        nrst;
  logic        dispReq;
  logic [12:0] dispAddr;
  logic        dispRdValid;
  logic [7:0]  dispRdData;
  logic        hostSelect;
  logic        hostRd;
  logic [12:0] hostAddr;
  logic [7:0]  hostWrData;
  logic [7:0]  hostRdData;
  logic        hostDone;
  logic        hostOverrun;
  logic [7:0]  hostWaitMax;
  logic [12:0] memAddr;
  logic [7:0]  memWrData;
  logic        memWe;
  logic [7:0]  memRdData;

  vram_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_W(8)) dut (
    .clk(clk), .nrst(nrst),
    .dispReq(dispReq), .dispAddr(dispAddr),
    .dispRdValid(dispRdValid), .dispRdData(dispRdData),
    .hostSelect(hostSelect), .hostRd(hostRd), .hostAddr(hostAddr),
    .hostWrData(hostWrData), .hostRdData(hostRdData), .hostDone(hostDone),
    .hostOverrun(hostOverrun), .hostWaitMax(hostWaitMax),
    .memAddr(memAddr), .memWrData(memWrData), .memWe(memWe),
    .memRdData(memRdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    init_val = 8'(a * 37 + 5);
  endfunction

  // Behavioural VRAM with registered read; contents loaded on the first edge.
  logic [7:0] vram [8192];
  bit         mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 8192; i++) vram[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else begin
      if (memWe) vram[memAddr] <= memWrData;
      memRdData <= vram[memAddr];
    end
  end

  typedef struct {
    logic       rd;
    logic [7:0] data;
  } host_t;

  typedef struct {
    logic        rst_n;
    logic        dreq;
    logic [12:0] daddr;
    logic        hsel;
    logic        hrd;
    logic [12:0] haddr;
    logic [7:0]  hwd;
    logic        push;
    logic [7:0]  exp_rdd;
    logic        exp_we;
    logic [12:0] exp_addr;
    logic        exp_done;
  } vec_t;

  logic [7:0] ref_mem [8192];
  logic [7:0] disp_q [$];
  host_t      host_q [$];
  int         n_cmp, n_err;
  int         we_cnt, done_cnt;
  logic       prev_dreq;
  vec_t       vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Record an accepted host access; writes update the reference image.
  task automatic host_push(input logic rd, input logic [12:0] addr, input logic [7:0] wd);
    host_t h;
    h.rd   = rd;
    h.data = rd ? ref_mem[addr] : wd;
    host_q.push_back(h);
    if (!rd) ref_mem[addr] = wd;
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later, scoreboard returns.
  task automatic cycle(input logic rst_n, input logic dreq, input logic [12:0] daddr,
                       input logic hsel, input logic hrd, input logic [12:0] haddr,
                       input logic [7:0] hwd);
    host_t h;
    @(negedge clk);
    nrst = rst_n; dispReq = dreq; dispAddr = daddr;
    hostSelect = hsel; hostRd = hrd; hostAddr = haddr; hostWrData = hwd;
    #1;
    check("disp_valid", {31'd0, dispRdValid}, {31'd0, prev_dreq});
    if (dispRdValid) begin
      if (disp_q.size() == 0) check("disp_unexpected", 32'd1, 32'd0);
      else check("disp_data", {24'd0, dispRdData}, {24'd0, disp_q.pop_front()});
    end
    if (hostDone) begin
      done_cnt++;
      if (host_q.size() == 0) check("host_done_unexpected", 32'd1, 32'd0);
      else begin
        h = host_q.pop_front();
        if (h.rd) check("host_rd_data", {24'd0, hostRdData}, {24'd0, h.data});
      end
    end
    if (memWe) we_cnt++;
    if (!rst_n) host_q.delete();
    if (rst_n && dreq) disp_q.push_back(ref_mem[daddr]);
    prev_dreq = rst_n & dreq;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
  endtask

  int we_base, done_base;

  initial begin
    n_cmp = 0; n_err = 0; we_cnt = 0; done_cnt = 0; prev_dreq = 1'b0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
    nrst = 1'b0; dispReq = 1'b0; dispAddr = '0; hostSelect = 1'b0;
    hostRd = 1'b0; hostAddr = '0; hostWrData = '0;
    repeat (2) @(posedge clk);

    // rst_n dreq daddr  hsel hrd haddr   hwd   push rdd   we addr    done
    vecs[0]  = '{1'b0, 1'b0, 13'h040, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 8'h00, 1'b0, 13'h040, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 13'h041, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 8'h00, 1'b0, 13'h041, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 13'h042, 1'b1, 1'b0, 13'h123, 8'h5A, 1'b1, 8'h00, 1'b0, 13'h042, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 13'h043, 1'b1, 1'b0, 13'h123, 8'h5A, 1'b0, 8'h00, 1'b1, 13'h123, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 13'h044, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 8'h00, 1'b0, 13'h044, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 13'h045, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 8'h00, 1'b0, 13'h045, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 13'h046, 1'b1, 1'b1, 13'h123, 8'h00, 1'b1, 8'h00, 1'b0, 13'h046, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 13'h047, 1'b1, 1'b1, 13'h123, 8'h00, 1'b0, 8'h00, 1'b0, 13'h123, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 13'h048, 1'b1, 1'b1, 13'h123, 8'h00, 1'b0, 8'h00, 1'b0, 13'h048, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 13'h049, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 8'h5A, 1'b0, 13'h049, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 13'h04A, 1'b0, 1'b0, 13'h000, 8'h00, 1'b0, 8'h5A, 1'b0, 13'h04A, 1'b0};

    for (int v = 0; v < 11; v++) begin
      cycle(vecs[v].rst_n, vecs[v].dreq, vecs[v].daddr, vecs[v].hsel,
            vecs[v].hrd, vecs[v].haddr, vecs[v].hwd);
      if (vecs[v].push) host_push(vecs[v].hrd, vecs[v].haddr, vecs[v].hwd);
      check("vec_mem_we",   {31'd0, memWe},       {31'd0, vecs[v].exp_we});
      check("vec_mem_addr", {19'd0, memAddr},     {19'd0, vecs[v].exp_addr});
      check("vec_done",     {31'd0, hostDone},    {31'd0, vecs[v].exp_done});
      check("vec_rd_data",  {24'd0, hostRdData},  {24'd0, vecs[v].exp_rdd});
      check("vec_overrun",  {31'd0, hostOverrun}, 32'd0);
      check("vec_wait_max", {24'd0, hostWaitMax}, 32'd0);
      if (vecs[v].exp_we) check("vec_wr_data", {24'd0, memWrData}, {24'd0, vecs[v].hwd});
    end

    // Host read stalled by 10 display fetches; RET overlaps a new display fetch.
    idle(1);
    cycle(1'b1, 1'b0, 13'h100, 1'b1, 1'b1, 13'h1FFF, 8'h00);
    host_push(1'b1, 13'h1FFF, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 13'(i), 1'b1, 1'b1, 13'h1FFF, 8'h00);
      check("stall_addr", {19'd0, memAddr}, i);
      check("stall_we", {31'd0, memWe}, 32'd0);
    end
    cycle(1'b1, 1'b0, 13'h200, 1'b1, 1'b1, 13'h1FFF, 8'h00);
    check("grant_addr", {19'd0, memAddr}, 32'h1FFF);
    cycle(1'b1, 1'b1, 13'h020, 1'b1, 1'b1, 13'h1FFF, 8'h00);
    check("ret_disp_addr", {19'd0, memAddr}, 32'h020);
    cycle(1'b1, 1'b0, 13'h000, 1'b0, 1'b0, 13'h000, 8'h00);
    check("ret_done", {31'd0, hostDone}, 32'd1);
    check("ret_disp_valid", {31'd0, dispRdValid}, 32'd1);
    check("wait_max_10", {24'd0, hostWaitMax}, 32'd10);

    // 300 stalled cycles saturate the wait statistic at 255.
    idle(1);
    cycle(1'b1, 1'b0, 13'h000, 1'b1, 1'b0, 13'h0800, 8'hC3);
    host_push(1'b0, 13'h0800, 8'hC3);
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 13'(i), 1'b1, 1'b0, 13'h0800, 8'hC3);
    cycle(1'b1, 1'b0, 13'h000, 1'b1, 1'b0, 13'h0800, 8'hC3);
    check("sat_we", {31'd0, memWe}, 32'd1);
    check("sat_addr", {19'd0, memAddr}, 32'h0800);
    idle(1);
    check("wait_max_sat", {24'd0, hostWaitMax}, 32'd255);

    // Second edge while pending: sticky overrun, only the first write happens.
    idle(1);
    we_base = we_cnt;
    cycle(1'b1, 1'b1, 13'h010, 1'b1, 1'b0, 13'h00A5, 8'h11);
    host_push(1'b0, 13'h00A5, 8'h11);
    cycle(1'b1, 1'b1, 13'h011, 1'b0, 1'b0, 13'h0000, 8'h00);
    check("ovr_before", {31'd0, hostOverrun}, 32'd0);
    cycle(1'b1, 1'b1, 13'h012, 1'b1, 1'b0, 13'h00B6, 8'h22);
    cycle(1'b1, 1'b1, 13'h013, 1'b1, 1'b0, 13'h00B6, 8'h22);
    check("ovr_set", {31'd0, hostOverrun}, 32'd1);
    cycle(1'b1, 1'b0, 13'h014, 1'b0, 1'b0, 13'h0000, 8'h00);
    check("ovr_wr_addr", {19'd0, memAddr}, 32'h00A5);
    check("ovr_wr_data", {24'd0, memWrData}, 32'h11);
    idle(4);
    check("ovr_we_count", we_cnt - we_base, 32'd1);
    check("ovr_sticky", {31'd0, hostOverrun}, 32'd1);

    // Reset while a write is pending: the write must never reach the VRAM.
    we_base = we_cnt;
    cycle(1'b1, 1'b1, 13'h011, 1'b1, 1'b0, 13'h0300, 8'h77);
    cycle(1'b1, 1'b1, 13'h011, 1'b1, 1'b0, 13'h0300, 8'h77);
    cycle(1'b0, 1'b0, 13'h012, 1'b1, 1'b0, 13'h0300, 8'h77);
    check("rst_we", {31'd0, memWe}, 32'd0);
    check("rst_addr", {19'd0, memAddr}, 32'h012);
    idle(4);
    check("rst_we_count", we_cnt - we_base, 32'd0);
    check("rst_overrun", {31'd0, hostOverrun}, 32'd0);
    check("rst_wait_max", {24'd0, hostWaitMax}, 32'd0);
    check("rst_rd_data", {24'd0, hostRdData}, 32'd0);
    check("rst_done", {31'd0, hostDone}, 32'd0);

    // hostSelect held 20 cycles: one access only; display return coincides with RET.
    done_base = done_cnt;
    we_base   = we_cnt;
    cycle(1'b1, 1'b0, 13'h000, 1'b1, 1'b1, 13'h0300, 8'h00);
    host_push(1'b1, 13'h0300, 8'h00);
    for (int j = 1; j < 20; j++) begin
      cycle(1'b1, (j == 2), 13'h005, 1'b1, 1'b1, 13'h0300, 8'h00);
      if (j == 3) begin
        check("hold_done", {31'd0, hostDone}, 32'd1);
        check("hold_disp_valid", {31'd0, dispRdValid}, 32'd1);
      end
    end
    idle(2);
    check("hold_done_count", done_cnt - done_base, 32'd1);
    check("hold_we_count", we_cnt - we_base, 32'd0);
    check("host_q_empty", host_q.size(), 32'd0);
    check("disp_q_empty", disp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
